traffic_phase_decoder: RTL and testbench

- Parametrised, registered binary-to-one-hot phase decoder for the traffic light controller.
- Extends plain 2-to-4 decoding to `2**SEL_W` lamp-group outputs.
- Adds an autonomous sequencing mode that steps through phases with a programmable dwell time, plus load, enable and phase-done signalling.
- Sits between the controller FSM and the lamp drivers: the FSM either drives the phase directly or lets this block sequence the phases.

---
 rtl/traffic_phase_decoder.sv | 113 +++++++++++
 tb/tb_traffic_phase_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_decoder.sv
// traffic_phase_decoder
//
// Registered binary-to-one-hot phase decoder with an autonomous sequencing mode.
// The decoder sits between the controller FSM and the lamp drivers.
// In direct mode, the FSM picks the phase on sel.
// In auto mode, this block steps through the phases itself, holding each one for
// dwell+1 enabled cycles.
//
// Optional feature, selected by the macro TRAFFIC_PHASE_GAP_EN:
//   When the macro is defined, every auto-mode advance inserts one all-red
//   clearance cycle. In that cycle out=0 and gap=1, and phase already shows the
//   new index.
//   When the macro is undefined, gap is constant 0.
//
// Parameters:
//   SEL_W   - phase index width
//   OUT_N   - number of one-hot outputs (derived, do not override)
//   DWELL_W - dwell counter width
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   en         - block enable; 0 freezes state and blanks out
//   mode       - 0 = direct decode of sel, 1 = auto sequencing
//   sel        - phase index (direct mode and load)
//   dwell      - per-phase hold count (phase lasts dwell+1 cycles)
//   load       - force phase to sel and restart the dwell count
//   out        - registered one-hot lamp-group enables
//   phase      - registered current phase index
//   phase_done - one-cycle pulse on each auto-mode advance
//   gap        - clearance-interval flag
module traffic_phase_decoder #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned OUT_N   = 2 ** SEL_W,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               load,
    output logic [OUT_N-1:0]   out,
    output logic [SEL_W-1:0]   phase,
    output logic               phase_done,
    output logic               gap
);

`ifdef TRAFFIC_PHASE_GAP_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif

    logic [SEL_W-1:0]   phase_q, phase_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               gap_q, gap_d;
    logic               done_q, done_d;
    logic [OUT_N-1:0]   out_q, out_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        out_d   = '0;

        if (!en) begin
            // Frozen: phase, cnt and gap hold; outputs blank.
        end else if (load || !mode) begin
            phase_d = sel;
            cnt_d   = dwell;
            gap_d   = 1'b0;
        end else if (GapEn && gap_q) begin
            // Clearance cycle is over. The reloaded dwell count starts only now.
            gap_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end else begin
            // OUT_N is a power of two, so the natural wrap gives modulo OUT_N.
            phase_d = phase_q + SEL_W'(1);
            cnt_d   = dwell;
            done_d  = 1'b1;
            gap_d   = GapEn;
        end

        if (en && !gap_d) begin
            out_d[phase_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign out        = out_q;
    assign phase      = phase_q;
    assign phase_done = done_q;
    assign gap        = gap_q;

endmodule

// File: tb/tb_traffic_phase_decoder.sv
// Directed self-checking bench for traffic_phase_decoder (SEL_W=2, DWELL_W=8).
// Expected values follow the gap feature when TRAFFIC_PHASE_GAP_EN is defined.
module tb_traffic_phase_decoder;

`ifdef TRAFFIC_PHASE_GAP_EN
    localparam bit GapEn = 1'b1;
`else
    localparam bit GapEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, load;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] out;
    logic [1:0] phase;
    logic       phase_done, gap;

    int total = 0;
    int bad   = 0;

    traffic_phase_decoder #(
        .SEL_W   (2),
        .DWELL_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .sel        (sel),
        .dwell      (dwell),
        .load       (load),
        .out        (out),
        .phase      (phase),
        .phase_done (phase_done),
        .gap        (gap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the outputs at an auto-mode advance, whose value depends on the gap build.
    task automatic check_advance(input string tag, input logic [1:0] p);
        check({tag, "_phase"}, 32'(phase), 32'(p));
        check({tag, "_done"}, 32'(phase_done), 32'd1);
        check({tag, "_out"}, 32'(out), GapEn ? 32'd0 : (32'd1 << p));
        check({tag, "_gap"}, 32'(gap), 32'(GapEn));
    endtask

    logic [3:0] seq_exp[$];

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0; dwell = '0;
        #12;
        check("rst_out", 32'(out), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_done", 32'(phase_done), 32'd0);
        check("rst_gap", 32'(gap), 32'd0);
        rst_n = 1'b1;
        step();

        // Reach phase 2 in auto mode, then assert reset asynchronously between edges.
        en = 1'b1; mode = 1'b1; load = 1'b1; sel = 2'd2; dwell = 8'd5;
        step();
        load = 1'b0;
        step();
        check("auto_pre_rst_phase", 32'(phase), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'd0);
        check("async_rst_phase", 32'(phase), 32'd0);
        check("async_rst_done", 32'(phase_done), 32'd0);
        #1 rst_n = 1'b1;
        mode = 1'b0; sel = 2'd0;
        step();
        check("post_rst_out", 32'(out), 32'b0001);

        // Direct decode of every phase.
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step();
            check("direct_out", 32'(out), 32'd1 << s);
            check("direct_phase", 32'(phase), 32'(s));
            check("direct_done", 32'(phase_done), 32'd0);
        end

        // Auto mode with dwell=3 from phase 3: hold 4 cycles, then wrap to 0.
        mode = 1'b1; load = 1'b1; sel = 2'd3; dwell = 8'd3;
        step();
        load = 1'b0;
        check("a3_hold_out", 32'(out), 32'b1000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("a3_hold_phase", 32'(phase), 32'd3);
            check("a3_hold_done", 32'(phase_done), 32'd0);
        end
        step();
        check_advance("a3_wrap", 2'd0);
        step();
        check("a3_done_clear", 32'(phase_done), 32'd0);

        // Auto mode with dwell=5: freeze mid-phase; the phase still totals 6 enabled cycles.
        load = 1'b1; sel = 2'd1; dwell = 8'd5;
        step();
        load = 1'b0;
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("en_off_out", 32'(out), 32'd0);
            check("en_off_phase", 32'(phase), 32'd1);
            check("en_off_done", 32'(phase_done), 32'd0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_back_out", 32'(out), 32'b0010);
        end
        step();
        check_advance("en_back_adv", 2'd2);

        // A load arriving on the same edge as a due advance wins.
        load = 1'b1; sel = 2'd0; dwell = 8'd1;
        step();
        load = 1'b0;
        step();
        load = 1'b1; sel = 2'd2;
        step();
        load = 1'b0;
        check("ld_win_phase", 32'(phase), 32'd2);
        check("ld_win_done", 32'(phase_done), 32'd0);
        check("ld_win_gap", 32'(gap), 32'd0);
        step();
        check("ld_hold_phase", 32'(phase), 32'd2);
        step();
        check_advance("ld_next_adv", 2'd3);

        // Lamp sequence with dwell=1 starting from phase 0.
        if (GapEn) begin
            seq_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
        end else begin
            seq_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
        end
        load = 1'b1; sel = 2'd0; dwell = 8'd1;
        step();
        load = 1'b0;
        foreach (seq_exp[i]) begin
            if (i != 0) step();
            check("seq_out", 32'(out), 32'(seq_exp[i]));
        end

        // Returning to direct mode follows sel on the next edge.
        mode = 1'b0; sel = 2'd3;
        step();
        check("to_direct_phase", 32'(phase), 32'd3);
        check("to_direct_out", 32'(out), 32'b1000);
        check("to_direct_gap", 32'(gap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
